alu_exec_unit: RTL and testbench

Parametrised execute-stage ALU for the pipelined MIPS core. It merges the Func/ALU_Mid control decode with a registered datapath, and adds shifts, `lui`, unsigned compare, and an iterative multiply/divide engine with HI/LO registers. It sits in EX: ID/EX issues operations via a valid/ready handshake, and `busy` stalls the front of the pipeline while a multi-cycle operation runs.

---
 rtl/alu_pkg.sv | 86 ++++++++
 rtl/alu_muldiv_seq.sv | 184 ++++++++++++++++++
 rtl/alu_exec_unit.sv | 137 +++++++++++++
 tb/tb_alu_exec_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: decoded ops, field codes, mul/div FSM states.
package alu_pkg;

   localparam int unsigned FUNC_W = 6;
   localparam int unsigned MID_W  = 3;
   localparam int unsigned OP_W   = 5;

   // R-type function field codes
   localparam logic [FUNC_W-1:0] FN_SLL   = 6'b000000;
   localparam logic [FUNC_W-1:0] FN_SRL   = 6'b000010;
   localparam logic [FUNC_W-1:0] FN_SRA   = 6'b000011;
   localparam logic [FUNC_W-1:0] FN_XNOR  = 6'b001100;
   localparam logic [FUNC_W-1:0] FN_MFHI  = 6'b010000;
   localparam logic [FUNC_W-1:0] FN_MTHI  = 6'b010001;
   localparam logic [FUNC_W-1:0] FN_MFLO  = 6'b010010;
   localparam logic [FUNC_W-1:0] FN_MTLO  = 6'b010011;
   localparam logic [FUNC_W-1:0] FN_MULT  = 6'b011000;
   localparam logic [FUNC_W-1:0] FN_MULTU = 6'b011001;
   localparam logic [FUNC_W-1:0] FN_DIV   = 6'b011010;
   localparam logic [FUNC_W-1:0] FN_DIVU  = 6'b011011;
   localparam logic [FUNC_W-1:0] FN_ADD   = 6'b100000;
   localparam logic [FUNC_W-1:0] FN_ADDU  = 6'b100001;
   localparam logic [FUNC_W-1:0] FN_SUB   = 6'b100010;
   localparam logic [FUNC_W-1:0] FN_SUBU  = 6'b100011;
   localparam logic [FUNC_W-1:0] FN_AND   = 6'b100100;
   localparam logic [FUNC_W-1:0] FN_OR    = 6'b100101;
   localparam logic [FUNC_W-1:0] FN_XOR   = 6'b100110;
   localparam logic [FUNC_W-1:0] FN_SLT   = 6'b101010;
   localparam logic [FUNC_W-1:0] FN_SLTU  = 6'b101011;

   // I-type class codes
   localparam logic [MID_W-1:0] MID_ADD   = 3'b000;
   localparam logic [MID_W-1:0] MID_SUB   = 3'b001;
   localparam logic [MID_W-1:0] MID_AND   = 3'b010;
   localparam logic [MID_W-1:0] MID_OR    = 3'b011;
   localparam logic [MID_W-1:0] MID_XOR   = 3'b100;
   localparam logic [MID_W-1:0] MID_SLT   = 3'b101;
   localparam logic [MID_W-1:0] MID_LUI   = 3'b110;
   localparam logic [MID_W-1:0] MID_RTYPE = 3'b111;

   // Decoded operation; low four bits keep the legacy ALU_Op codes
   typedef enum logic [OP_W-1:0] {
      OP_AND     = 5'b00000,
      OP_OR      = 5'b00001,
      OP_XOR     = 5'b00010,
      OP_XNOR    = 5'b00011,
      OP_ADD     = 5'b00100,
      OP_SLL     = 5'b00101,
      OP_SRL     = 5'b00110,
      OP_SRA     = 5'b00111,
      OP_LUI     = 5'b01000,
      OP_MFHI    = 5'b01001,
      OP_MFLO    = 5'b01010,
      OP_MTHI    = 5'b01011,
      OP_SUB     = 5'b01100,
      OP_SLT     = 5'b01101,
      OP_SLTU    = 5'b01110,
      OP_MTLO    = 5'b01111,
      OP_MULT    = 5'b10000,
      OP_MULTU   = 5'b10001,
      OP_DIV     = 5'b10010,
      OP_DIVU    = 5'b10011,
      OP_ILLEGAL = 5'b11111
   } alu_op_e;

   // Multi-cycle operation selector; matches the low bits of OP_MULT..OP_DIVU
   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } md_state_e;

   // True for operations handled by the iterative mul/div engine
   function automatic logic is_md_op(input alu_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step per cycle, owns HI/LO.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  md_op_e           md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             idle_c,
   output logic             busy_c,
   output logic             md_done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   md_state_e          state;
   md_state_e          state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   opnd;
   logic               is_mul;
   logic               zero_div;
   logic               neg_lo;
   logic               neg_hi;

   logic               is_mul_op_c;
   logic               signed_op_c;
   logic               b_zero_c;
   logic               last_c;
   logic               a_neg_c;
   logic               b_neg_c;
   logic [WIDTH-1:0]   a_mag_c;
   logic [WIDTH-1:0]   b_mag_c;
   logic               step_mul_c;
   logic               step_div_c;
   logic               finish_c;
   logic [WIDTH:0]     mul_sum_c;
   logic [WIDTH:0]     div_shift_c;
   logic               div_ge_c;
   logic [WIDTH-1:0]   div_rem_c;
   logic [2*WIDTH-1:0] prod_c;
   logic [2*WIDTH-1:0] prod_fix_c;

   assign is_mul_op_c = (md_op == MD_MULT) || (md_op == MD_MULTU);
   assign signed_op_c = (md_op == MD_MULT) || (md_op == MD_DIV);
   assign b_zero_c    = (b == '0);
   assign last_c      = (cnt == CNT_W'(WIDTH - 1));

   // Signed ops iterate on magnitudes; sign is restored when results are committed
   assign a_neg_c = signed_op_c && a[WIDTH-1];
   assign b_neg_c = signed_op_c && b[WIDTH-1];
   assign a_mag_c = a_neg_c ? -a : a;
   assign b_mag_c = b_neg_c ? -b : b;

   // One iteration of each algorithm
   assign mul_sum_c   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
   assign div_shift_c = {acc_hi, acc_lo[WIDTH-1]};
   assign div_ge_c    = (div_shift_c >= {1'b0, opnd});
   assign div_rem_c   = WIDTH'(div_shift_c - {1'b0, opnd});
   assign prod_c      = {acc_hi, acc_lo};
   assign prod_fix_c  = neg_lo ? -prod_c : prod_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; divide by zero skips the iterations entirely
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (is_mul_op_c)   state_nxt = ST_MUL;
               else if (b_zero_c) state_nxt = ST_DONE;
               else               state_nxt = ST_DIV;
            end
         end
         ST_MUL, ST_DIV: if (last_c) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded controls
   always_comb begin
      idle_c     = 1'b0;
      busy_c     = 1'b0;
      step_mul_c = 1'b0;
      step_div_c = 1'b0;
      finish_c   = 1'b0;
      case (state)
         ST_IDLE: idle_c = 1'b1;
         ST_MUL: begin
            busy_c     = 1'b1;
            step_mul_c = 1'b1;
         end
         ST_DIV: begin
            busy_c     = 1'b1;
            step_div_c = 1'b1;
         end
         ST_DONE: begin
            busy_c   = 1'b1;
            finish_c = 1'b1;
         end
         default: idle_c = 1'b0;
      endcase
   end

   // Engine datapath, HI/LO and completion pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         is_mul   <= 1'b0;
         zero_div <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         md_done  <= 1'b0;
         div0     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         md_done <= 1'b0;
         div0    <= 1'b0;
         if (idle_c && start) begin
            cnt      <= '0;
            is_mul   <= is_mul_op_c;
            zero_div <= !is_mul_op_c && b_zero_c;
            opnd     <= b_mag_c;
            neg_lo   <= a_neg_c ^ b_neg_c;
            neg_hi   <= a_neg_c;
            if (!is_mul_op_c && b_zero_c) begin
               acc_hi <= a;
               acc_lo <= '1;
            end else begin
               acc_hi <= '0;
               acc_lo <= a_mag_c;
            end
         end
         if (step_mul_c) begin
            acc_hi <= mul_sum_c[WIDTH:1];
            acc_lo <= {mul_sum_c[0], acc_lo[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
         end
         if (step_div_c) begin
            acc_hi <= div_ge_c ? div_rem_c : div_shift_c[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge_c};
            cnt    <= cnt + 1'b1;
         end
         if (finish_c) begin
            md_done <= 1'b1;
            div0    <= zero_div;
            if (zero_div) begin
               hi <= acc_hi;
               lo <= acc_lo;
            end else if (is_mul) begin
               {hi, lo} <= prod_fix_c;
            end else begin
               lo <= neg_lo ? -acc_lo : acc_lo;
               hi <= neg_hi ? -acc_hi : acc_hi;
            end
         end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: Func/ALU_Mid decode, registered single-cycle datapath, iterative mul/div.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       Func,
   input  logic [2:0]       ALU_Mid,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic [WIDTH-1:0] Result,
   output logic             illegal,
   output logic             busy,
   output logic             md_done,
   output logic             div0,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned HALF = WIDTH / 2;

   alu_op_e          alu_op_c;
   logic [WIDTH-1:0] res_c;
   logic             accept_c;
   logic             is_md_c;
   logic             md_start_c;
   logic             wr_hi_c;
   logic             wr_lo_c;

   assign accept_c   = in_valid && in_ready;
   assign is_md_c    = is_md_op(alu_op_c);
   assign md_start_c = accept_c && is_md_c;
   assign wr_hi_c    = accept_c && (alu_op_c == OP_MTHI);
   assign wr_lo_c    = accept_c && (alu_op_c == OP_MTLO);

   // Decode ALU_Mid / Func into an internal operation code
   always_comb begin
      alu_op_c = OP_ILLEGAL;
      case (ALU_Mid)
         MID_ADD: alu_op_c = OP_ADD;
         MID_SUB: alu_op_c = OP_SUB;
         MID_AND: alu_op_c = OP_AND;
         MID_OR:  alu_op_c = OP_OR;
         MID_XOR: alu_op_c = OP_XOR;
         MID_SLT: alu_op_c = OP_SLT;
         MID_LUI: alu_op_c = OP_LUI;
         default: begin
            case (Func)
               FN_ADD, FN_ADDU: alu_op_c = OP_ADD;
               FN_SUB, FN_SUBU: alu_op_c = OP_SUB;
               FN_AND:          alu_op_c = OP_AND;
               FN_OR:           alu_op_c = OP_OR;
               FN_XOR:          alu_op_c = OP_XOR;
               FN_XNOR:         alu_op_c = OP_XNOR;
               FN_SLT:          alu_op_c = OP_SLT;
               FN_SLTU:         alu_op_c = OP_SLTU;
               FN_SLL:          alu_op_c = OP_SLL;
               FN_SRL:          alu_op_c = OP_SRL;
               FN_SRA:          alu_op_c = OP_SRA;
               FN_MFHI:         alu_op_c = OP_MFHI;
               FN_MFLO:         alu_op_c = OP_MFLO;
               FN_MTHI:         alu_op_c = OP_MTHI;
               FN_MTLO:         alu_op_c = OP_MTLO;
               FN_MULT:         alu_op_c = OP_MULT;
               FN_MULTU:        alu_op_c = OP_MULTU;
               FN_DIV:          alu_op_c = OP_DIV;
               FN_DIVU:         alu_op_c = OP_DIVU;
               default:         alu_op_c = OP_ILLEGAL;
            endcase
         end
      endcase
   end

   // Single-cycle result; shifts act on B, illegal ops produce zero
   always_comb begin
      res_c = '0;
      case (alu_op_c)
         OP_ADD:           res_c = A + B;
         OP_SUB:           res_c = A - B;
         OP_AND:           res_c = A & B;
         OP_OR:            res_c = A | B;
         OP_XOR:           res_c = A ^ B;
         OP_XNOR:          res_c = ~(A ^ B);
         OP_SLT:           res_c = WIDTH'($signed(A) < $signed(B));
         OP_SLTU:          res_c = WIDTH'(A < B);
         OP_SLL:           res_c = B << shamt;
         OP_SRL:           res_c = B >> shamt;
         OP_SRA:           res_c = $unsigned($signed(B) >>> shamt);
         OP_LUI:           res_c = {B[HALF-1:0], {HALF{1'b0}}};
         OP_MFHI:          res_c = HI;
         OP_MFLO:          res_c = LO;
         OP_MTHI, OP_MTLO: res_c = A;
         default:          res_c = '0;
      endcase
   end

   // Registered result and one-cycle valid/illegal pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         illegal   <= 1'b0;
         Result    <= '0;
      end else begin
         out_valid <= accept_c && !is_md_c;
         illegal   <= accept_c && (alu_op_c == OP_ILLEGAL);
         if (accept_c && !is_md_c) Result <= res_c;
      end
   end

   alu_muldiv_seq #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (md_start_c),
      .md_op   (md_op_e'(alu_op_c[1:0])),
      .a       (A),
      .b       (B),
      .wr_hi   (wr_hi_c),
      .wr_lo   (wr_lo_c),
      .wdata   (A),
      .idle_c  (in_ready),
      .busy_c  (busy),
      .md_done (md_done),
      .div0    (div0),
      .hi      (HI),
      .lo      (LO)
   );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench: WIDTH=32 and WIDTH=16 units against a plain-arithmetic reference model.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  fn;
   logic [2:0]  mid;
   logic        v32, v16;
   logic [4:0]  sh32;
   logic [3:0]  sh16;
   logic [31:0] a32, b32;
   logic [15:0] a16, b16;

   logic        rdy32, ov32, ill32, busy32, mdd32, dz32;
   logic [31:0] res32, hi32, lo32;
   logic        rdy16, ov16, ill16, busy16, mdd16, dz16;
   logic [15:0] res16, hi16, lo16;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] mh32 = '0, ml32 = '0, mh16 = '0, ml16 = '0;

   logic [5:0]  fn_tab [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h0C,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h11, 6'h13};

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .Func(fn), .ALU_Mid(mid),
      .shamt(sh32), .A(a32), .B(b32), .out_valid(ov32), .Result(res32), .illegal(ill32),
      .busy(busy32), .md_done(mdd32), .div0(dz32), .HI(hi32), .LO(lo32));

   alu_exec_unit #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .Func(fn), .ALU_Mid(mid),
      .shamt(sh16), .A(a16), .B(b16), .out_valid(ov16), .Result(res16), .illegal(ill16),
      .busy(busy16), .md_done(mdd16), .div0(dz16), .HI(hi16), .LO(lo16));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mask(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [63:0] sx(input logic [63:0] x, input int w);
      return x[w-1] ? (x | ~mask(w)) : (x & mask(w));
   endfunction

   // Reference for single-cycle ops at width w (operands already reduced to w bits)
   function automatic void ref_single(input int w, input logic [2:0] m, input logic [5:0] f,
                                      input int sh, input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] hi, input logic [63:0] lo,
                                      output logic [63:0] res, output logic ill);
      logic signed [63:0] sa, sb;
      sa  = sx(a, w);
      sb  = sx(b, w);
      ill = 1'b0;
      res = '0;
      case (m)
         3'd0: res = a + b;
         3'd1: res = a - b;
         3'd2: res = a & b;
         3'd3: res = a | b;
         3'd4: res = a ^ b;
         3'd5: res = (sa < sb) ? 64'd1 : 64'd0;
         3'd6: res = (b & mask(w / 2)) << (w / 2);
         default: begin
            case (f)
               6'h20, 6'h21: res = a + b;
               6'h22, 6'h23: res = a - b;
               6'h24:        res = a & b;
               6'h25:        res = a | b;
               6'h26:        res = a ^ b;
               6'h0C:        res = ~(a ^ b);
               6'h2A:        res = (sa < sb) ? 64'd1 : 64'd0;
               6'h2B:        res = (a < b) ? 64'd1 : 64'd0;
               6'h00:        res = b << sh;
               6'h02:        res = b >> sh;
               6'h03:        res = sb >>> sh;
               6'h10:        res = hi;
               6'h12:        res = lo;
               6'h11, 6'h13: res = a;
               default:      ill = 1'b1;
            endcase
         end
      endcase
      res = res & mask(w);
   endfunction

   // Reference for 32-bit multiply/divide results
   function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic z);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] p;
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      z  = 1'b0;
      hi = '0;
      lo = '0;
      if (f == 6'h18) begin
         p = 64'(sa * sb);
         hi = p[63:32]; lo = p[31:0];
      end else if (f == 6'h19) begin
         p = {32'd0, a} * {32'd0, b};
         hi = p[63:32]; lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a; lo = '1; z = 1'b1;
      end else if (f == 6'h1A) begin
         q = sa / sb; r = sa % sb;
         hi = r[31:0]; lo = q[31:0];
      end else begin
         lo = a / b; hi = a % b;
      end
   endfunction

   // Issue one single-cycle op to both units and check everything visible after the accept edge
   task automatic step(input logic [2:0] m, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
      logic [63:0] e32, e16;
      logic        i32, i16;
      ref_single(32, m, f, int'(sh), {32'd0, a}, {32'd0, b}, mh32, ml32, e32, i32);
      ref_single(16, m, f, int'(sh[3:0]), {48'd0, a[15:0]}, {48'd0, b[15:0]}, mh16, ml16, e16, i16);
      chk("ready32", rdy32, 1);
      chk("ready16", rdy16, 1);
      mid = m; fn = f; sh32 = sh; sh16 = sh[3:0];
      a32 = a; b32 = b; a16 = a[15:0]; b16 = b[15:0];
      v32 = 1'b1; v16 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0; v16 = 1'b0;
      if (m == 3'd7 && f == 6'h11) begin mh32 = {32'd0, a}; mh16 = {48'd0, a[15:0]}; end
      if (m == 3'd7 && f == 6'h13) begin ml32 = {32'd0, a}; ml16 = {48'd0, a[15:0]}; end
      chk("out_valid32", ov32, 1);
      chk("result32", res32, e32);
      chk("illegal32", ill32, i32);
      chk("hi32", hi32, mh32);
      chk("lo32", lo32, ml32);
      chk("out_valid16", ov16, 1);
      chk("result16", res16, e16);
      chk("illegal16", ill16, i16);
      chk("hi16", hi16, mh16);
      chk("lo16", lo16, ml16);
   endtask

   // Run one mul/div on the 32-bit unit and check latency, HI/LO, div0 and pulse width
   task automatic md32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el;
      logic        ez;
      int          n;
      ref_md(f, a, b, eh, el, ez);
      chk("md_ready", rdy32, 1);
      mid = 3'd7; fn = f; a32 = a; b32 = b; v32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0;
      chk("md_busy", busy32, 1);
      chk("md_no_valid", ov32, 0);
      n = 0;
      while (mdd32 !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("md_latency", n, ez ? 1 : 33);
      chk("md_hi", hi32, eh);
      chk("md_lo", lo32, el);
      chk("md_div0", dz32, ez);
      chk("md_ready_back", rdy32, 1);
      mh32 = {32'd0, eh};
      ml32 = {32'd0, el};
      @(posedge clk); #1;
      chk("md_done_pulse", mdd32, 0);
      chk("div0_pulse", dz32, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_8000;
         3:       return 32'h7FFF_7FFF;
         4:       return 32'h8000_0000;
         5:       return 32'h0000_0001;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic [5:0]  f;
      logic [31:0] eh, el;
      logic        ez;
      int          n, done_at;

      rst_n = 1'b0; v32 = 1'b0; v16 = 1'b0; fn = '0; mid = '0;
      sh32 = '0; sh16 = '0; a32 = '0; b32 = '0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", res32, 0);
      chk("rst_hi", hi32, 0);
      chk("rst_lo", lo32, 0);
      chk("rst_valid", ov32, 0);
      chk("rst_illegal", ill32, 0);
      chk("rst_md_done", mdd32, 0);
      chk("rst_div0", dz32, 0);
      chk("rst_busy", busy32, 0);
      chk("rst_ready", rdy32, 1);
      chk("rst_ready16", rdy16, 1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // All-ones / one sweep over every single-cycle code
      for (int i = 0; i < 17; i++) step(3'd7, fn_tab[i], 5'd3, 32'hFFFF_FFFF, 32'h1);
      for (int i = 0; i < 7; i++) step(3'(i), 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h1);
      step(3'd7, 6'h20, 5'd0, 32'hFFFF_FFFF, 32'h1);
      chk("add_wrap", res32, 32'h0);
      step(3'd7, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'h1);
      chk("slt_signed", res32, 32'h1);
      step(3'd7, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'h1);
      chk("sltu_unsigned", res32, 32'h0);
      step(3'd7, 6'h03, 5'd4, 32'h8000_0000, 32'h8000_0000);
      chk("sra_fill", res32, 32'hF800_0000);
      step(3'd6, 6'h00, 5'd0, 32'h0, 32'h0000_00AB);
      chk("lui16", res16, 16'hAB00);

      // Illegal code pulses for exactly one cycle
      step(3'd7, 6'h3F, 5'd0, 32'h1234_5678, 32'h9);
      chk("illegal_flag", ill32, 1);
      @(posedge clk); #1;
      chk("illegal_pulse", ill32, 0);
      chk("valid_pulse", ov32, 0);

      // mthi/mtlo visible to an mfhi/mflo accepted on the next edge
      step(3'd7, 6'h11, 5'd0, 32'hCAFE_F00D, 32'h0);
      step(3'd7, 6'h10, 5'd0, 32'h0, 32'h0);
      step(3'd7, 6'h13, 5'd0, 32'h1357_9BDF, 32'h0);
      step(3'd7, 6'h12, 5'd0, 32'h0, 32'h0);

      // Multiply / divide, including signed corners and divide by zero
      md32(6'h18, 32'hFFFF_FFFD, 32'd7);
      md32(6'h19, 32'hFFFF_FFFD, 32'd7);
      md32(6'h1A, 32'hFFFF_FFF9, 32'd2);
      md32(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
      md32(6'h1B, 32'd5, 32'd0);
      md32(6'h1A, 32'hFFFF_FFF0, 32'd0);
      md32(6'h1B, 32'hFFFF_FFFF, 32'h8000_0000);
      for (int i = 0; i < 6; i++) md32(6'h18 + 6'(i % 4), $urandom(), pick());
      step(3'd7, 6'h10, 5'd0, 32'h0, 32'h0);
      step(3'd7, 6'h12, 5'd0, 32'h0, 32'h0);

      // Randomized single-cycle traffic, back-to-back
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) f = 6'($urandom());
         else f = fn_tab[$urandom_range(0, 16)];
         if (f inside {6'h18, 6'h19, 6'h1A, 6'h1B}) f = 6'h3F;
         step(3'($urandom()), f, 5'($urandom()), pick(), pick());
      end

      // An add held during a mult is accepted only once the unit is free
      ref_md(6'h18, 32'hFFFF_FFFD, 32'd7, eh, el, ez);
      mid = 3'd7; fn = 6'h18; a32 = 32'hFFFF_FFFD; b32 = 32'd7; v32 = 1'b1;
      @(posedge clk); #1;
      fn = 6'h20; a32 = 32'h0000_1000; b32 = 32'h0000_0234;
      n = 0; done_at = 0;
      while (ov32 !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (mdd32 === 1'b1) done_at = n;
      end
      v32 = 1'b0;
      chk("hold_accept_cycle", n, 34);
      chk("hold_md_done_cycle", done_at, 33);
      chk("hold_result", res32, 32'h0000_1234);
      chk("hold_hi", hi32, eh);
      chk("hold_lo", lo32, el);
      mh32 = {32'd0, eh};
      ml32 = {32'd0, el};

      // Reset during a mult aborts it and clears HI/LO
      mid = 3'd7; fn = 6'h18; a32 = 32'h0001_0001; b32 = 32'h0002_0003; v32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_hi", hi32, 0);
      chk("abort_lo", lo32, 0);
      chk("abort_busy", busy32, 0);
      chk("abort_ready", rdy32, 1);
      mh32 = '0; ml32 = '0; mh16 = '0; ml16 = '0;
      @(negedge clk); rst_n = 1'b1;
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (mdd32 === 1'b1) n++;
      end
      chk("abort_no_md_done", n, 0);
      step(3'd7, 6'h10, 5'd0, 32'h0, 32'h0);
      step(3'd7, 6'h22, 5'd0, 32'h0000_0005, 32'h0000_0007);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
